ptmch_trg_log: RTL
==================

// Module: ptmch_trg_log
// PURPOSE
//  Trigger event logger; sits directly downstream of the SPI-instruction trigger stage and consumes its TRG_PLS[4:0].
//  Each 0->1 edge on an enabled channel creates one entry {multi, ch_id, timestamp} in an on-chip FIFO that host logic drains.
//  Also keeps per-channel saturating event counts and a sticky overflow flag, for post-capture analysis of flash command traffic.
// PARAMETERS
//  P_CH         5   number of trigger channels (fixed by ptmch_pkg::PTMCH_CH_NUM)
//  P_TS_W       24  timestamp counter width; wraps 2^P_TS_W-1 -> 0
//  P_CNT_W      16  per-channel event counter width
//  P_FIFO_DEPTH 16  log FIFO depth in entries; power of two, >=2
// PORTS
//  CLK160M   in   1                  sole clock, 160 MHz
//  RESET     in   1                  synchronous, active-high reset
//  TRG_PLS   in   P_CH               trigger pulses from upstream, CLK160M domain, >=2 cycles high
//  CH_EN     in   P_CH               per-channel log/count enable, quasi-static
//  CLR       in   1                  sync clear: FIFO, counters, OVF, timestamp
//  RD_VALID  out  1                  RD_DATA holds the FIFO head entry
//  RD_READY  in   1                  pop head when RD_VALID & RD_READY at posedge
//  RD_DATA   out  1+3+P_TS_W         {multi, ch_id[2:0], ts[P_TS_W-1:0]}
//  FIFO_LVL  out  $clog2(DEPTH)+1    entries currently held, 0..P_FIFO_DEPTH
//  EVT_CNT   out  P_CH*P_CNT_W       channel i count at [i*P_CNT_W +: P_CNT_W]
//  OVF       out  1                  sticky: >=1 entry dropped on full FIFO
// BEHAVIOUR
//  Reset (RESET=1 at posedge): RD_VALID=0, RD_DATA=0, FIFO_LVL=0, EVT_CNT=0, OVF=0, ts=0, pointers=0. The input edge regs trg_q/trg_qq are forced to all-ones, so a pulse held across reset release is not logged. RESET overrides CLR.
//  Input path: trg_q<=TRG_PLS; trg_qq<=trg_q; rise = trg_q & ~trg_qq & CH_EN.
//  Timestamp: free-running ts increments every cycle and wraps silently. An entry carries the ts value of the cycle in which rise is asserted.
//  Latency: TRG_PLS first sampled high at edge k -> rise during cycle k..k+1 -> entry written at edge k+1 -> RD_VALID=1 after edge k+1 if the FIFO was empty. No fall-through.
//  Multiple rises in one cycle: every rising channel's EVT_CNT increments. One entry is written, with ch_id = lowest index and multi=1. A single rise gives multi=0.
//  EVT_CNT[i] saturates at all-ones and does not wrap.
//  FIFO: show-ahead; RD_DATA is valid whenever RD_VALID=1 and stable until popped. RD_READY while RD_VALID=0 is ignored.
//  Full + write, no pop: entry dropped, OVF<=1, EVT_CNT still increments.
//  Full + write + pop in the same cycle: both happen, FIFO_LVL unchanged, no drop.
//  Empty + write + RD_READY: write only; the entry is visible next cycle.
//  Pointers wrap modulo P_FIFO_DEPTH. FIFO_LVL is a registered count, so it cannot be confused between full and empty.
//  CLR=1: at that edge, FIFO is flushed (RD_VALID=0 next cycle), EVT_CNT=0, OVF=0, ts=0. A rise in the same cycle is discarded, neither logged nor counted. trg_q/trg_qq keep updating.
//  RESET mid-capture: all entries are lost; no partial entry may ever appear on RD_DATA.
// CONFIGURATION
//  PTMCH_TRG_LOG_DROPCNT_EN defined:
//   adds output DROP_CNT [15:0]. It counts entries dropped on full, saturates at 16'hFFFF, and is cleared by RESET and CLR. OVF == (DROP_CNT!=0).
//  PTMCH_TRG_LOG_DROPCNT_EN undefined:
//   no DROP_CNT port and no counter logic; OVF is a plain sticky bit.
// STRUCTURE
//  Package ptmch_pkg holds:
//   - PTMCH_CH_NUM=5
//   - channel index constants CH_PROG_EXEC=0, CH_RD_STATUS=1, CH_BLK_ERASE=2, CH_PAGE_READ=3, CH_WR_STATUS=4
//   - typedef struct packed ptmch_trg_entry_t {multi; ch_id[2:0]; ts}; TS width is a package localparam matching P_TS_W
//  Sub-module ptmch_sync_fifo (WIDTH, DEPTH): single-clock, show-ahead, sync active-high reset and flush input, full/empty/level outputs.
//  Top level keeps edge detect, priority encode, timestamp, counters, OVF/drop logic.
// TESTING
//  1 Pulse TRG_PLS[2] high 16 cycles, CH_EN=5'h1F, ts=100 at first sample -> one entry {0,3'd2,ts=101}; RD_VALID 2 cycles after first sample; EVT_CNT[2]=1.
//  2 TRG_PLS=5'b01010 rising together -> one entry with ch_id=1, multi=1; EVT_CNT[1]=EVT_CNT[3]=1.
//  3 17 pulses on ch0 with RD_READY=0, DEPTH=16 -> FIFO_LVL=16, OVF=1, EVT_CNT[0]=17, DROP_CNT=1 (macro on); the 16 entries pop in order with increasing ts.
//  4 FIFO full, rise coincides with RD_READY=1 -> LVL stays 16, OVF stays 0, newest entry at tail.
//  5 CH_EN=5'h1E, pulse ch0 -> no entry, EVT_CNT[0]=0. CLR coinciding with a ch4 rise -> FIFO empty, all counters 0.
//  6 TRG_PLS[3] held high through RESET deassertion -> no entry. Separately, ts at 2^24-1 -> next entry ts=0. Separately, EVT_CNT preset to 16'hFFFF -> stays 16'hFFFF.

Source files
------------

// File: rtl/ptmch_pkg.sv
// ptmch_pkg: shared constants, trigger-channel indices and the log entry layout.
package ptmch_pkg;

    localparam int unsigned PTMCH_CH_NUM  = 5;
    localparam int unsigned PTMCH_TS_W    = 24;
    localparam int unsigned PTMCH_ID_W    = 3;
    localparam int unsigned PTMCH_ENTRY_W = 1 + PTMCH_ID_W + PTMCH_TS_W;

    localparam int unsigned CH_PROG_EXEC = 0;
    localparam int unsigned CH_RD_STATUS = 1;
    localparam int unsigned CH_BLK_ERASE = 2;
    localparam int unsigned CH_PAGE_READ = 3;
    localparam int unsigned CH_WR_STATUS = 4;

    typedef logic [PTMCH_CH_NUM-1:0] ptmch_ch_vec_t;

    typedef struct packed {
        logic                  multi;
        logic [PTMCH_ID_W-1:0] ch_id;
        logic [PTMCH_TS_W-1:0] ts;
    } ptmch_trg_entry_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [PTMCH_ID_W-1:0] ptmch_lowest_ch(input ptmch_ch_vec_t v);
        logic [PTMCH_ID_W-1:0] id;
        logic                  found;
        ptmch_ch_vec_t         t;
        id    = '0;
        found = 1'b0;
        t     = v;
        for (int unsigned i = 0; i < PTMCH_CH_NUM; i++) begin
            if (!found && t[0]) begin
                id    = PTMCH_ID_W'(i);
                found = 1'b1;
            end
            t = t >> 1;
        end
        return id;
    endfunction

    // True when more than one bit is set.
    function automatic logic ptmch_is_multi(input ptmch_ch_vec_t v);
        return (v & (v - ptmch_ch_vec_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/ptmch_sync_fifo.sv
// ptmch_sync_fifo: single-clock show-ahead FIFO with sync reset/flush and a registered level.
module ptmch_sync_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_level == '0);
    assign full    = (r_level == LW'(DEPTH));
    assign level   = r_level;
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_wr && !w_do_rd)      r_level <= r_level + LW'(1);
            else if (!w_do_wr && w_do_rd) r_level <= r_level - LW'(1);
        end
    end

    // Storage array; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_do_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ptmch_trg_log.sv
// ptmch_trg_log: logs rising trigger edges as {multi, ch_id, ts} entries, counts events per channel,
// and flags entries lost on a full FIFO. Define PTMCH_TRG_LOG_DROPCNT_EN to add the DROP_CNT output.
module ptmch_trg_log
    import ptmch_pkg::*;
#(
    parameter int unsigned P_CNT_W      = 16,
    parameter int unsigned P_FIFO_DEPTH = 16
) (
    input  logic                              CLK160M,
    input  logic                              RESET,
    input  logic [PTMCH_CH_NUM-1:0]           TRG_PLS,
    input  logic [PTMCH_CH_NUM-1:0]           CH_EN,
    input  logic                              CLR,
    output logic                              RD_VALID,
    input  logic                              RD_READY,
    output logic [PTMCH_ENTRY_W-1:0]          RD_DATA,
    output logic [$clog2(P_FIFO_DEPTH):0]     FIFO_LVL,
    output logic [PTMCH_CH_NUM*P_CNT_W-1:0]   EVT_CNT,
`ifdef PTMCH_TRG_LOG_DROPCNT_EN
    output logic [15:0]                       DROP_CNT,
`endif
    output logic                              OVF
);

    localparam int unsigned P_CH   = PTMCH_CH_NUM;
    localparam int unsigned P_TS_W = PTMCH_TS_W;

    logic [P_CH-1:0]    r_trg_q;
    logic [P_CH-1:0]    r_trg_qq;
    logic [P_TS_W-1:0]  r_ts;
    logic [P_CNT_W-1:0] r_cnt [P_CH];
    logic               r_ovf;
    logic [P_CH-1:0]    w_rise;
    logic               w_wr;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    ptmch_trg_entry_t   w_entry;

    assign w_rise = r_trg_q & ~r_trg_qq & CH_EN;
    assign w_wr   = (w_rise != '0) & ~CLR;
    // Full implies a valid head, so RD_READY alone decides whether a slot frees up.
    assign w_drop = w_wr & w_full & ~RD_READY;

    // Entry built from the cycle in which the rise is seen.
    always_comb begin
        w_entry       = '0;
        w_entry.multi = ptmch_is_multi(w_rise);
        w_entry.ch_id = ptmch_lowest_ch(w_rise);
        w_entry.ts    = r_ts;
    end

    // Edge-detect pipeline; all-ones after reset hides pulses held across release.
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            r_trg_q  <= '1;
            r_trg_qq <= '1;
        end else begin
            r_trg_q  <= TRG_PLS;
            r_trg_qq <= r_trg_q;
        end
    end

    // Free-running timestamp, wraps silently.
    always_ff @(posedge CLK160M) begin
        if (RESET || CLR) r_ts <= '0;
        else              r_ts <= r_ts + P_TS_W'(1);
    end

    // Per-channel saturating event counters.
    for (genvar g = 0; g < P_CH; g++) begin : g_cnt
        always_ff @(posedge CLK160M) begin
            if (RESET || CLR)                     r_cnt[g] <= '0;
            else if (w_rise[g] && r_cnt[g] != '1) r_cnt[g] <= r_cnt[g] + P_CNT_W'(1);
        end
        assign EVT_CNT[g*P_CNT_W +: P_CNT_W] = r_cnt[g];
    end

    // Sticky overflow flag.
    always_ff @(posedge CLK160M) begin
        if (RESET || CLR) r_ovf <= 1'b0;
        else if (w_drop)  r_ovf <= 1'b1;
    end

`ifdef PTMCH_TRG_LOG_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of entries lost on a full FIFO.
    always_ff @(posedge CLK160M) begin
        if (RESET || CLR)                     r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + 16'(1);
    end

    assign DROP_CNT = r_drop_cnt;
`endif

    assign OVF      = r_ovf;
    assign RD_VALID = ~w_empty;

    ptmch_sync_fifo #(
        .WIDTH (PTMCH_ENTRY_W),
        .DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK160M),
        .rst     (RESET),
        .flush   (CLR),
        .wr_en   (w_wr),
        .wr_data (w_entry),
        .rd_en   (RD_READY),
        .rd_data (RD_DATA),
        .empty   (w_empty),
        .full    (w_full),
        .level   (FIFO_LVL)
    );

endmodule
